// File: rtl/shared_counter_sched.sv
// Round-robin scheduler that lends one shared up-counter to NREQ requesters.
// The winner's terminal value is latched at grant. The counter then runs from
// 0 up to that value, and the owner receives a one-cycle done pulse.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   req   : per-requester request level
//   term  : packed terminal values, requester i at term[i*WIDTH +: WIDTH]
//   grant : one-hot current owner, zero when idle
//   count : shared counter value
//   busy  : high whenever the scheduler is not idle
//   done  : one-cycle completion pulse to the owner
module shared_counter_sched #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   term,
    output logic [NREQ-1:0]         grant,
    output logic [WIDTH-1:0]        count,
    output logic                    busy,
    output logic [NREQ-1:0]         done
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [WIDTH-1:0]   term_q, term_d;
    logic [NREQ-1:0]    grant_d;
    logic [WIDTH-1:0]   count_d;
    logic               busy_d;
    logic [NREQ-1:0]    done_d;

    logic [IW-1:0]      win;
    logic               win_found;
    logic [IW-1:0]      owner_next;

    // First requester at or after the pointer, wrapping modulo NREQ
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!win_found && req[(int'(ptr_q) + i) % int'(NREQ)]) begin
                win       = IW'((int'(ptr_q) + i) % int'(NREQ));
                win_found = 1'b1;
            end
        end
    end

    // The owner moves to the lowest priority once its turn ends
    assign owner_next = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an abort takes priority over reaching the terminal value
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (win_found) state_d = RUN;
            RUN: begin
                if (!req[owner_q]) begin
                    state_d = IDLE;
                end else if (count == term_q) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for the registered outputs and the datapath
    always_comb begin
        grant_d = grant;
        count_d = count;
        done_d  = '0;
        term_d  = term_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                count_d = '0;
                if (win_found) begin
                    owner_d = win;
                    term_d  = term[win*WIDTH +: WIDTH];
                    grant_d = NREQ'(1) << win;
                end
            end
            RUN: begin
                if (!req[owner_q]) begin
                    grant_d = '0;
                    count_d = '0;
                    ptr_d   = owner_next;
                end else if (count == term_q) begin
                    done_d = grant;
                end else begin
                    count_d = count + WIDTH'(1);
                end
            end
            DONE: begin
                grant_d = '0;
                count_d = '0;
                ptr_d   = owner_next;
            end
            default: begin
                grant_d = '0;
                count_d = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant   <= '0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= '0;
            term_q  <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            grant   <= grant_d;
            count   <= count_d;
            busy    <= busy_d;
            done    <= done_d;
            term_q  <= term_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: doc/shared_counter_sched.md
Name: shared_counter_sched

Overview:
Round-robin scheduler that shares one WIDTH-bit up-counter among NREQ requesters. Each requester asks for a timed interval of (term+1) counts. The block grants the counter to one requester at a time, runs it from 0 to that requester's terminal value, and returns a one-cycle done pulse. It sits between the requesting control FSMs and the counter datapath, and owns the counter register itself.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 4, counter and terminal-value width in bits

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
req  input  NREQ  per-requester request level; held high until done or abandoned
term  input  NREQ*WIDTH  packed terminal values; requester i uses term[i*WIDTH +: WIDTH]
grant  output  NREQ  one-hot owner of the counter; all-zero when idle
count  output  WIDTH  current shared counter value
busy  output  1  high whenever state != IDLE
done  output  NREQ  one-cycle completion pulse to the owner

Behaviour:
- Reset (rst=0, asynchronous, no clk needed): state=IDLE, grant=0, count=0, busy=0, done=0, rr pointer=0. Outputs leave reset values only on the first rising clk edge after rst=1.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - If req!=0, select the first set bit at or after the pointer, wrapping modulo NREQ.
  - On the next edge: latch term of the winner into term_q, set grant to winner one-hot, count=0, go to RUN.
  - If req==0, stay in IDLE; count stays 0.
- RUN:
  - If the owner's req=0 (abort): next edge goes to IDLE, grant=0, count=0, no done pulse, pointer=owner+1 mod NREQ.
  - Else if count==term_q: next edge goes to DONE; count holds.
  - Else: count<=count+1.
- DONE: lasts exactly one cycle.
  - done[owner]=1, grant still asserted, count holds term_q.
  - Next edge: IDLE, grant=0, done=0, count=0, pointer=owner+1 mod NREQ.
- Timing for terminal value T with no contention:
  - grant rises one edge after req is sampled in IDLE.
  - count sequence is 0..T, with T+1 RUN cycles.
  - done pulses in the cycle after count first equals T.
  - grant is high for T+2 cycles in total.
- Between grants there is at least one IDLE cycle.
- term is sampled only at grant. Changes to term or to non-owner req during RUN/DONE are ignored.
- Boundaries:
  - term=0 gives one RUN cycle at count=0, then DONE.
  - term=2^WIDTH-1 counts to max with no wrap; the counter never exceeds term_q.
  - If the owner keeps req high after done, it is re-eligible but has the lowest priority after rotation.
  - Abort and count==term_q in the same cycle: abort wins, no done pulse.
  - Reset mid-RUN: immediate return to reset values; no done pulse.
- Invariants: grant is one-hot or zero; done is a subset of grant; done is never high outside DONE.

Test Plan:
1. Reset release, then req[0]=1 with term0=5 -> grant=0001 one cycle later; count 0,1,2,3,4,5; done[0] pulses one cycle with count=5; grant high for 7 cycles; then grant=0, count=0.
2. req=1111 simultaneously, all terms=2 and held -> grants in order 0001,0010,0100,1000,0001; each grant lasts 4 cycles; exactly one IDLE cycle between grants; one done pulse per owner.
3. req[2]=1 with term2=0 -> one RUN cycle at count=0, done[2] on the next cycle, grant high for 2 cycles. Then term2=15 -> count reaches 15 without wrapping and done[2] fires once.
4. Abort: req[1] granted with term1=9; drop req[1] while count=3 -> next cycle IDLE, grant=0, count=0, no done[1]; a pending req[2] is granted next.
5. Async reset: assert rst=0 mid-RUN at count=6, between clk edges -> grant, count, busy, done are 0 immediately; after release, the pointer restarts at requester 0.
6. Change term0 from 5 to 1 while requester 0 owns the counter at count=2 -> the run still ends at count=5 and done[0] fires at the original time.
